bcnn_binarize_maxpool2x2: RTL and testbench
===========================================

Name: bcnn_binarize_maxpool2x2

Overview:
Downstream stage of the 3x3 binary convolution. Consumes the raster-ordered popcount stream (popcount + valid, one per output pixel of the conv). Binarizes each popcount against a threshold, then applies a 2x2, stride-2 max-pool, which is a logical OR on binary data. Emits one pooled bit per window, with coordinates and an end-of-frame pulse, for the next binary layer.

Parameters:
IN_COLS, 26, columns of incoming feature map (conv output width)
IN_ROWS, 26, rows of incoming feature map
SUM_WIDTH, 4, width of popcount_in and threshold
OUT_COLS, IN_COLS/2 (derived localparam, floor), pooled columns
OUT_ROWS, IN_ROWS/2 (derived localparam, floor), pooled rows

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
popcount_in  input  SUM_WIDTH  conv popcount, raster order, row-major
valid_in  input  1  popcount_in valid this cycle; gaps allowed, no backpressure
threshold  input  SUM_WIDTH  binarization threshold; bit = (popcount >= threshold)
bit_out  output  1  pooled binary value
valid_out  output  1  bit_out/out_row/out_col valid (1-cycle pulse per window)
out_row  output  $clog2(OUT_ROWS)  pooled row index of bit_out
out_col  output  $clog2(OUT_COLS)  pooled column index of bit_out
frame_done  output  1  1-cycle pulse after last input pixel of a frame accepted

Behaviour:
- Reset is synchronous. Reset clears in_row, in_col, h_reg, the line buffer, bit_out, valid_out, out_row, out_col and frame_done, all to 0. thr_lat is undefined until the first pixel is accepted.
- in_col and in_row are unsigned counters. Both advance only on valid_in. in_col wraps at IN_COLS-1 and increments in_row. in_row wraps at IN_ROWS-1 to 0, which starts the next frame.
- Threshold handling:
  - On the pixel at (0,0), the value on threshold is used directly and also latched into thr_lat.
  - Every other pixel of the frame compares against thr_lat. Changes on threshold mid-frame have no effect until the next frame.
  - The compare is unsigned, with b = 1 when popcount_in >= thr.
- Horizontal pair, per accepted pixel:
  - Even in_col: h_reg <= b.
  - Odd in_col: pair = h_reg | b, computed combinationally.
- Vertical pair:
  - Even in_row, odd in_col: line buffer entry lb[in_col>>1] <= pair. The line buffer is OUT_COLS bits.
  - Odd in_row, odd in_col: on the next edge, bit_out <= lb[in_col>>1] | pair, valid_out <= 1, out_row <= in_row>>1, out_col <= in_col>>1.
- Latency: valid_out is high in the cycle immediately after the edge that accepts the bottom-right pixel of a window. valid_out is 0 in all other cycles. bit_out, out_row and out_col hold their values while valid_out is low.
- Odd-dimension truncation:
  - If IN_COLS is odd, the last column (in_col = IN_COLS-1) updates nothing except the counters.
  - If IN_ROWS is odd, the last row produces no output.
  - Counters still traverse the full IN_COLS x IN_ROWS.
- frame_done is registered. It is high for one cycle after the edge accepting (IN_ROWS-1, IN_COLS-1). When both dimensions are even, this is the same cycle as the final valid_out.
- Back-to-back frames need no idle cycles. Line buffer entries are overwritten on each even row before they are read, so no clearing between frames is required.
- Reset asserted mid-frame: counters return to 0 and the next valid_in pixel is treated as (0,0). There is no valid_out from the partial window, including when reset and a completing pixel arrive in the same cycle, since reset wins.
- valid_in low: no state changes. valid_out and frame_done are 0 on the following cycle.
- No internal backpressure. Throughput is one pixel per clock.

Decomposition:
- Shared package bcnn_pkg holds:
  - SUM_WIDTH default
  - IN_COLS/IN_ROWS defaults for the 28x28 input, 3x3 kernel configuration (26x26)
  - a clog2-based index-width helper constant
- One natural sub-module: bcnn_line_buffer_bits, an OUT_COLS x 1-bit register array with a synchronous write port and a combinational read port.
- The counters, binarizer and OR tree stay in the top.

Test Plan:
- 26x26, all popcount = 9, threshold = 5 -> 169 valid_out pulses, all bit_out = 1, (out_row,out_col) sweeping (0,0)..(12,12) in raster order, exactly one frame_done, coincident with the last valid_out.
- All popcount = 4, threshold = 5 -> 169 outputs all 0. Repeat with threshold = 4 -> all 1 (boundary of >=).
- Single pixel popcount = 5 at input (3,5), all others 0, threshold = 5 -> only output (1,2) = 1, all other 168 are 0. Repeat at (2,4) -> same output (1,2) = 1.
- Random valid_in gaps (about 30% idle) with random popcounts -> outputs match a software OR-pool model bit-exactly. valid_out is never asserted on cycles not preceded by an accepted odd-row/odd-col pixel.
- Threshold changed from 5 to 9 at input (10,0) mid-frame -> the frame still uses 5. The next frame uses 9.
- Reset asserted at input (7,13), then a full frame -> no output from the aborted frame, and the new frame yields 169 outputs starting at (0,0). Separately, with IN_COLS = IN_ROWS = 5 -> 4 outputs, and frame_done after the 25th pixel.

Source files
------------

// File: rtl/bcnn_pkg.sv
// Shared defaults and helpers for the binary CNN pooling stages.
package bcnn_pkg;

  localparam int unsigned SUM_WIDTH_DEF = 4;
  localparam int unsigned IN_COLS_DEF   = 26;
  localparam int unsigned IN_ROWS_DEF   = 26;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bcnn_line_buffer_bits.sv
// One row of pooled horizontal pairs: synchronous write, combinational read.
module bcnn_line_buffer_bits
  import bcnn_pkg::*;
#(
  parameter int unsigned DEPTH = IN_COLS_DEF / 2,
  parameter int unsigned AW    = idx_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_bit,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_bit_c
);

  logic [DEPTH-1:0] mem;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_bit;
    end
  end

  assign rd_bit_c = mem[rd_addr];

endmodule

// File: rtl/bcnn_binarize_maxpool2x2.sv
// Binarizes a raster popcount stream against a per-frame threshold and
// OR-pools 2x2 stride-2 windows, emitting one bit per window.
module bcnn_binarize_maxpool2x2
  import bcnn_pkg::*;
#(
  parameter int unsigned IN_COLS   = IN_COLS_DEF,
  parameter int unsigned IN_ROWS   = IN_ROWS_DEF,
  parameter int unsigned SUM_WIDTH = SUM_WIDTH_DEF,
  localparam int unsigned OUT_COLS = IN_COLS / 2,
  localparam int unsigned OUT_ROWS = IN_ROWS / 2,
  localparam int unsigned CW       = idx_w(IN_COLS),
  localparam int unsigned RW       = idx_w(IN_ROWS),
  localparam int unsigned OCW      = idx_w(OUT_COLS),
  localparam int unsigned ORW      = idx_w(OUT_ROWS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SUM_WIDTH-1:0] popcount_in,
  input  logic                 valid_in,
  input  logic [SUM_WIDTH-1:0] threshold,
  output logic                 bit_out,
  output logic                 valid_out,
  output logic [ORW-1:0]       out_row,
  output logic [OCW-1:0]       out_col,
  output logic                 frame_done
);

  logic [CW-1:0]        in_col;
  logic [RW-1:0]        in_row;
  logic                 h_reg;
  logic [SUM_WIDTH-1:0] thr_lat;

  logic                 first_px, last_col, last_row, col_ok, row_ok;
  logic [SUM_WIDTH-1:0] thr_c;
  logic                 b, pair, lb_we, emit, lb_rd_c;
  logic [OCW-1:0]       pair_idx;

  // Pixel decode: threshold select, binarize, horizontal OR and window control.
  always_comb begin
    first_px = (in_col == '0) && (in_row == '0);
    last_col = (in_col == CW'(IN_COLS - 1));
    last_row = (in_row == RW'(IN_ROWS - 1));
    col_ok   = (32'(in_col) < 2 * OUT_COLS);
    row_ok   = (32'(in_row) < 2 * OUT_ROWS);
    thr_c    = first_px ? threshold : thr_lat;
    b        = (popcount_in >= thr_c);
    pair     = h_reg | b;
    pair_idx = OCW'(in_col >> 1);
    lb_we    = valid_in && col_ok && row_ok && in_col[0] && !in_row[0];
    emit     = valid_in && col_ok && row_ok && in_col[0] && in_row[0];
  end

  // Raster counters and the left half of the current horizontal pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_col <= '0;
      in_row <= '0;
      h_reg  <= 1'b0;
    end else if (valid_in) begin
      if (col_ok && !in_col[0]) begin
        h_reg <= b;
      end
      if (last_col) begin
        in_col <= '0;
        in_row <= last_row ? '0 : in_row + RW'(1);
      end else begin
        in_col <= in_col + CW'(1);
      end
    end
  end

  // Threshold is sampled once per frame; it has no meaningful reset value.
  always_ff @(posedge clk) begin
    if (valid_in && first_px) begin
      thr_lat <= threshold;
    end
  end

  bcnn_line_buffer_bits #(
    .DEPTH(OUT_COLS),
    .AW   (OCW)
  ) u_lb (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (lb_we),
    .wr_addr (pair_idx),
    .wr_bit  (pair),
    .rd_addr (pair_idx),
    .rd_bit_c(lb_rd_c)
  );

  // Registered window result; data fields hold between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_out    <= 1'b0;
      valid_out  <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= emit;
      frame_done <= valid_in && last_col && last_row;
      if (emit) begin
        bit_out <= lb_rd_c | pair;
        out_row <= ORW'(in_row >> 1);
        out_col <= OCW'(in_col >> 1);
      end
    end
  end

endmodule

// File: tb/tb_bcnn_binarize_maxpool2x2.sv
// Scoreboard bench: stimulus pushes OR-pool model results, a monitor pops on valid_out.
module tb_bcnn_binarize_maxpool2x2;

  localparam int C  = 26;
  localparam int R  = 26;
  localparam int SC = 5;
  localparam int SR = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [3:0] popcount_in = '0, threshold = '0, pop_s = '0, thr_s = '0;
  logic       valid_in = 1'b0, valid_s = 1'b0;
  logic       bit_out, valid_out, frame_done;
  logic [3:0] out_row, out_col;
  logic       bit_s, vout_s, fd_s;
  logic [0:0] orow_s, ocol_s;

  bcnn_binarize_maxpool2x2 u_dut (
    .clk(clk), .reset(reset), .popcount_in(popcount_in), .valid_in(valid_in),
    .threshold(threshold), .bit_out(bit_out), .valid_out(valid_out),
    .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
  );

  bcnn_binarize_maxpool2x2 #(.IN_COLS(SC), .IN_ROWS(SR)) u_small (
    .clk(clk), .reset(reset), .popcount_in(pop_s), .valid_in(valid_s),
    .threshold(thr_s), .bit_out(bit_s), .valid_out(vout_s),
    .out_row(orow_s), .out_col(ocol_s), .frame_done(fd_s)
  );

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] c;
    logic       b;
  } exp_t;

  exp_t q[$];
  exp_t qs[$];
  int   total = 0, bad = 0;
  int   outs = 0, ones = 0, fds = 0, last_one_r = -1, last_one_c = -1;
  int   outs_s = 0, ones_s = 0;
  int   img[R][C];
  logic mon_on = 1'b0;
  logic cur_emit = 1'b0, cur_fd = 1'b0, cur_emit_s = 1'b0, cur_fd_s = 1'b0;
  logic exp_vo = 1'b0, exp_fd = 1'b0, exp_vs = 1'b0, exp_fds = 1'b0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_vo  <= cur_emit;
    exp_fd  <= cur_fd;
    exp_vs  <= cur_emit_s;
    exp_fds <= cur_fd_s;
  end

  // Monitor: pulse timing every cycle, payload against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      check("valid_out_timing", int'(valid_out), int'(exp_vo));
      check("frame_done_timing", int'(frame_done), int'(exp_fd));
      check("small_valid_out_timing", int'(vout_s), int'(exp_vs));
      check("small_frame_done_timing", int'(fd_s), int'(exp_fds));
      if (frame_done) fds++;
      if (valid_out) begin
        outs++;
        if (bit_out) begin
          ones++;
          last_one_r = int'(out_row);
          last_one_c = int'(out_col);
        end
        if (q.size() == 0) check("unexpected_output", 1, 0);
        else begin
          e = q.pop_front();
          check("out_row", int'(out_row), int'(e.r));
          check("out_col", int'(out_col), int'(e.c));
          check("bit_out", int'(bit_out), int'(e.b));
        end
      end
      if (vout_s) begin
        outs_s++;
        if (bit_s) ones_s++;
        if (qs.size() == 0) check("small_unexpected_output", 1, 0);
        else begin
          e = qs.pop_front();
          check("small_out_row", int'(orow_s), int'(e.r));
          check("small_out_col", int'(ocol_s), int'(e.c));
          check("small_bit_out", int'(bit_s), int'(e.b));
        end
      end
    end
  end

  function automatic logic pool_bit(input int wr, input int wc, input int thr);
    logic r = 1'b0;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (img[2*wr+dr][2*wc+dc] >= thr) r = 1'b1;
    return r;
  endfunction

  task automatic fill(input int v);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) img[r][c] = v;
  endtask

  task automatic drive(input logic v, input int p, input int t, input logic em, input logic fd);
    @(posedge clk);
    #1;
    valid_in    = v;
    popcount_in = 4'(p);
    threshold   = 4'(t);
    cur_emit    = em;
    cur_fd      = fd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, int'(threshold), 1'b0, 1'b0);
  endtask

  task automatic clear_counts();
    outs = 0; ones = 0; fds = 0; last_one_r = -1; last_one_c = -1;
  endtask

  // One 26x26 frame; chg_row >= 0 switches the threshold input from (chg_row,0) on.
  task automatic run_frame(input int t0, input int chg_row, input int t1, input int idle_pct,
                           input int abort_r, input int abort_c);
    exp_t e;
    int   t;
    int   abort_idx = (abort_r >= 0) ? abort_r * C + abort_c : R * C;
    for (int wr = 0; wr < R / 2; wr++)
      for (int wc = 0; wc < C / 2; wc++)
        if ((2*wr+1) * C + (2*wc+1) < abort_idx) begin
          e.r = 4'(wr); e.c = 4'(wc); e.b = pool_bit(wr, wc, t0);
          q.push_back(e);
        end
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        if (idle_pct > 0 && $urandom_range(0, 99) < idle_pct) idle(1);
        t = (chg_row >= 0 && r >= chg_row) ? t1 : t0;
        if (r * C + c == abort_idx) begin
          @(posedge clk);
          #1;
          reset = 1'b1; valid_in = 1'b1; popcount_in = 4'(img[r][c]);
          cur_emit = 1'b0; cur_fd = 1'b0;
          @(posedge clk);
          #1;
          reset = 1'b0; valid_in = 1'b0;
          return;
        end
        drive(1'b1, img[r][c], t, (r % 2 == 1) && (c % 2 == 1), (r == R-1) && (c == C-1));
      end
  endtask

  task automatic drive_s(input logic v, input int p, input logic em, input logic fd);
    @(posedge clk);
    #1;
    valid_s = v; pop_s = 4'(p); thr_s = 4'd5; cur_emit_s = em; cur_fd_s = fd;
  endtask

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid_out", int'(valid_out), 0);
    check("reset_bit_out", int'(bit_out), 0);
    check("reset_out_row", int'(out_row), 0);
    check("reset_out_col", int'(out_col), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("small_reset_valid_out", int'(vout_s), 0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_on = 1'b1;

    // All ones, then the >= boundary on both sides.
    clear_counts(); fill(9); run_frame(5, -1, 0, 0, -1, 0); idle(4);
    check("allhigh_outs", outs, 169); check("allhigh_ones", ones, 169);
    check("allhigh_frame_done", fds, 1); check("allhigh_drained", q.size(), 0);
    clear_counts(); fill(4); run_frame(5, -1, 0, 0, -1, 0); idle(4);
    check("below_thr_ones", ones, 0); check("below_thr_outs", outs, 169);
    clear_counts(); fill(4); run_frame(4, -1, 0, 0, -1, 0); idle(4);
    check("equal_thr_ones", ones, 169);

    // Single hot pixel in the bottom-right and top-left corner of window (1,2).
    clear_counts(); fill(0); img[3][5] = 5; run_frame(5, -1, 0, 0, -1, 0); idle(4);
    check("single_35_ones", ones, 1); check("single_35_row", last_one_r, 1);
    check("single_35_col", last_one_c, 2);
    clear_counts(); fill(0); img[2][4] = 5; run_frame(5, -1, 0, 0, -1, 0); idle(4);
    check("single_24_ones", ones, 1); check("single_24_row", last_one_r, 1);
    check("single_24_col", last_one_c, 2);

    // Random popcounts with idle gaps.
    clear_counts();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) img[r][c] = $urandom_range(0, 9);
    run_frame(5, -1, 0, 30, -1, 0); idle(4);
    check("random_outs", outs, 169); check("random_drained", q.size(), 0);

    // Mid-frame threshold change only applies from the next frame (back-to-back).
    clear_counts(); fill(7);
    run_frame(5, 10, 9, 0, -1, 0);
    run_frame(9, -1, 0, 0, -1, 0); idle(4);
    check("thr_change_ones", ones, 169); check("thr_change_outs", outs, 338);
    check("thr_change_frame_done", fds, 2);

    // Reset on a window-completing pixel, then a clean frame.
    clear_counts(); fill(9); run_frame(5, -1, 0, 0, 7, 13);
    check("abort_outs", outs, 45); check("abort_drained", q.size(), 0);
    idle(2);
    clear_counts(); run_frame(5, -1, 0, 0, -1, 0); idle(4);
    check("after_abort_outs", outs, 169); check("after_abort_ones", ones, 169);

    // 5x5 instance: odd last row/column truncated; only window (0,0) is hot.
    fill(0);
    for (int i = 0; i < SC; i++) begin img[4][i] = 9; img[i][4] = 9; end
    img[1][1] = 9;
    for (int wr = 0; wr < 2; wr++)
      for (int wc = 0; wc < 2; wc++) begin
        e.r = 4'(wr); e.c = 4'(wc); e.b = pool_bit(wr, wc, 5); qs.push_back(e);
      end
    for (int r = 0; r < SR; r++)
      for (int c = 0; c < SC; c++)
        drive_s(1'b1, img[r][c], (r % 2 == 1) && (c % 2 == 1) && (r < 4) && (c < 4),
                (r == SR-1) && (c == SC-1));
    drive_s(1'b0, 0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("small_outs", outs_s, 4); check("small_ones", ones_s, 1);
    check("small_drained", qs.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
